// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status out; also carries the receiver's debug taps.
interface uart_receiver_if;
  logic       din;
  logic [7:0] data_rx;
  logic       valid;
  logic       ferr;
  logic       busy;
  logic [1:0] state;
  logic [2:0] index;
  logic [8:0] counter;

  modport master (
    input  din,
    output data_rx, valid, ferr, busy, state, index, counter
  );

  modport slave (
    output din,
    input  data_rx, valid, ferr, busy, state, index, counter
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises din, samples each bit at mid-bit, emits the byte
// with a one-cycle valid strobe or a one-cycle ferr strobe on a bad stop bit.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 278
) (
  input  logic            clk,
  input  logic            rst,
  uart_receiver_if.master rx
);
  localparam logic [8:0] HALF_M1 = 9'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0] BIT_M1  = 9'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sync_q;
  logic       s_din;
  logic       armed_q, armed_d;
  logic [8:0] counter_q, counter_d;
  logic [2:0] index_q, index_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  assign s_din = sync_q[1];

  // NOTE: every flop here is assigned with <= so all of them update from the same
  // pre-edge values; the shift register and data_rx are ordinary flops, not a memory,
  // so they are cleared by reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      counter_q <= '0;
      index_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx.din};
      state_q   <= state_d;
      armed_q   <= armed_d;
      counter_q <= counter_d;
      index_q   <= index_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d   = state_q;
    armed_d   = 1'b0;
    counter_d = counter_q;
    index_d   = index_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        index_d   = '0;
        // A line held low after a framing error must go high once before a new start counts.
        armed_d   = armed_q | s_din;
        if (armed_q && !s_din) begin
          state_d = START;
        end
      end

      START: begin
        counter_d = counter_q + 9'd1;
        if (counter_q == HALF_M1) begin
          counter_d = '0;
          state_d   = s_din ? IDLE : DATA;
        end
      end

      DATA: begin
        counter_d = counter_q + 9'd1;
        if (counter_q == BIT_M1) begin
          counter_d        = '0;
          shift_d[index_q] = s_din;
          index_d          = index_q + 3'd1;
          if (index_q == 3'd7) begin
            index_d = '0;
            state_d = STOP;
          end
        end
      end

      STOP: begin
        counter_d = counter_q + 9'd1;
        if (counter_q == BIT_M1) begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
          counter_d = '0;
          state_d   = IDLE;
          if (s_din) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx.busy    = (state_q != IDLE);
    rx.state   = state_q;
    rx.index   = index_q;
    rx.counter = counter_q;
    rx.data_rx = data_q;
    rx.valid   = valid_q;
    rx.ferr    = ferr_q;
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a vector table of frames plus hand-written
// glitch, framing-error, mid-frame reset and baud-tolerance sequences.
module tb_uart_receiver;
  localparam int CPB    = 278;
  localparam int HALF   = CPB / 2;
  localparam int CPB_F  = 16;
  localparam int LAT_LO = HALF + 9 * CPB + 1;
  localparam int LAT_HI = HALF + 9 * CPB + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_receiver_if bus ();
  uart_receiver_if bus_f ();

  uart_receiver #(.CLKS_PER_BIT(CPB))   u_dut  (.clk(clk), .rst(rst), .rx(bus));
  uart_receiver #(.CLKS_PER_BIT(CPB_F)) u_fast (.clk(clk), .rst(rst), .rx(bus_f));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling edge.
  int   cyc = 0;
  int   valid_cnt = 0, ferr_cnt = 0, wide_cnt = 0, both_cnt = 0, busy_rise = 0;
  int   last_valid_cyc = 0;
  int   valid_f = 0, ferr_f = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (prev_valid) wide_cnt++;
    end
    if (bus.ferr === 1'b1) begin
      ferr_cnt++;
      if (prev_ferr) wide_cnt++;
    end
    if (bus.valid === 1'b1 && bus.ferr === 1'b1) both_cnt++;
    if (bus.busy === 1'b1 && !prev_busy) busy_rise++;
    prev_valid = (bus.valid === 1'b1);
    prev_ferr  = (bus.ferr === 1'b1);
    prev_busy  = (bus.busy === 1'b1);
    if (bus_f.valid === 1'b1) valid_f++;
    if (bus_f.ferr === 1'b1) ferr_f++;
  end

  int t_start;

  task automatic send_bit(input logic b, input int clocks);
    bus.din = b;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    t_start = cyc;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
    send_bit(stop_bit, CPB);
  endtask

  task automatic send_frame_f(input logic [7:0] b, input int period);
    bus_f.din = 1'b0;
    #(period);
    for (int i = 0; i < 8; i++) begin
      bus_f.din = b[i];
      #(period);
    end
    bus_f.din = 1'b1;
    #(period);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         period;
  } fvec_t;

  vec_t  vecs [4];
  fvec_t fvecs[4];

  initial begin
    int v0, f0, r0, lat;

    // Gap 0 makes the next start bit follow the stop bit immediately.
    vecs[0] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};
    vecs[1] = '{8'h00, 1'b1, 20, 1, 0, 8'h00};
    vecs[2] = '{8'h55, 1'b1,  0, 1, 0, 8'h55};
    vecs[3] = '{8'hA3, 1'b1, 20, 1, 0, 8'hA3};
    fvecs[0] = '{8'hFF, 165};
    fvecs[1] = '{8'h00, 165};
    fvecs[2] = '{8'hFF, 155};
    fvecs[3] = '{8'h00, 155};

    rst       = 1'b1;
    bus.din   = 1'b1;
    bus_f.din = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data_rx", 32'(bus.data_rx), 32'h0);
    check("reset valid",   32'(bus.valid),   32'h0);
    check("reset ferr",    32'(bus.ferr),    32'h0);
    check("reset busy",    32'(bus.busy),    32'h0);
    check("reset state",   32'(bus.state),   32'h0);
    check("reset index",   32'(bus.index),   32'h0);
    check("reset counter", 32'(bus.counter), 32'h0);
    rst = 1'b0;
    send_bit(1'b1, 20);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      lat = last_valid_cyc - t_start;
      if (vecs[i].gap > 0) send_bit(1'b1, vecs[i].gap);
      check($sformatf("vec%0d valid count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d ferr count", i),  32'(ferr_cnt - f0),  32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d data_rx", i),     32'(bus.data_rx),    32'(vecs[i].exp_data));
      check($sformatf("vec%0d latency in range (lat %0d)", i, lat),
            32'(lat >= LAT_LO && lat <= LAT_HI), 32'h1);
    end

    // Glitch: 50 low clocks is shorter than half a bit.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.din = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch busy high", 32'(bus.busy), 32'h1);
    repeat (45) @(negedge clk);
    bus.din = 1'b1;
    repeat (HALF + 3 - 50) @(negedge clk);
    check("glitch state idle", 32'(bus.state), 32'h0);
    check("glitch busy low",   32'(bus.busy),  32'h0);
    check("glitch no valid",   32'(valid_cnt - v0), 32'h0);
    check("glitch no ferr",    32'(ferr_cnt - f0),  32'h0);
    send_bit(1'b1, CPB);

    // Framing error, then line held low for three bit times.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    r0 = busy_rise;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b0, 3 * CPB);
    check("ferr pulse count",     32'(ferr_cnt - f0),   32'h1);
    check("ferr no valid",        32'(valid_cnt - v0),  32'h0);
    check("ferr data_rx held",    32'(bus.data_rx),     32'hA3);
    check("ferr no retrigger",    32'(busy_rise - r0),  32'h1);
    check("ferr idle while low",  32'(bus.state),       32'h0);
    send_bit(1'b1, CPB);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, 20);
    check("after ferr valid",     32'(valid_cnt - v0),  32'h1);
    check("after ferr data_rx",   32'(bus.data_rx),     32'h81);
    check("after ferr no ferr",   32'(ferr_cnt - f0),   32'h1);

    // Reset early in data bit 4 of 0x96.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    begin
      logic [7:0] b;
      b = 8'h96;
      send_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) send_bit(b[i], CPB);
      send_bit(b[4], 10);
    end
    check("pre-reset busy",  32'(bus.busy),  32'h1);
    check("pre-reset index", 32'(bus.index), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("mid reset data_rx", 32'(bus.data_rx), 32'h0);
    check("mid reset valid",   32'(bus.valid),   32'h0);
    check("mid reset ferr",    32'(bus.ferr),    32'h0);
    check("mid reset busy",    32'(bus.busy),    32'h0);
    check("mid reset state",   32'(bus.state),   32'h0);
    check("mid reset index",   32'(bus.index),   32'h0);
    check("mid reset counter", 32'(bus.counter), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1, 2 * CPB);
    check("aborted frame no valid", 32'(valid_cnt - v0), 32'h0);
    check("aborted frame no ferr",  32'(ferr_cnt - f0),  32'h0);
    send_frame(8'h42, 1'b1);
    send_bit(1'b1, 20);
    check("post-reset valid",   32'(valid_cnt - v0), 32'h1);
    check("post-reset data_rx", 32'(bus.data_rx),    32'h42);

    // Baud tolerance on the 16-clock instance: +3.1% and -3.1% bit periods.
    for (int i = 0; i < 4; i++) begin
      v0 = valid_f;
      f0 = ferr_f;
      @(negedge clk);
      send_frame_f(fvecs[i].data, fvecs[i].period);
      #100;
      @(negedge clk);
      check($sformatf("tol%0d valid", i),   32'(valid_f - v0),    32'h1);
      check($sformatf("tol%0d ferr", i),    32'(ferr_f - f0),     32'h0);
      check($sformatf("tol%0d data_rx", i), 32'(bus_f.data_rx),   32'(fvecs[i].data));
    end

    check("pulses one clock wide",  32'(wide_cnt), 32'h0);
    check("valid and ferr exclusive", 32'(both_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver; the stage downstream of the UART transmitter on the serial line. It deserialises an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit) from `din`. It presents the byte on `data_rx` with a one-cycle `valid` strobe, and flags a bad stop bit with `ferr`. It runs on the same 32 MHz system clock as the transmitter, and its bit-timing parameter matches the transmitter's.

## Interface
- `CLKS_PER_BIT`, default 278: system clocks per bit (32 MHz / 115200 baud); legal range 4..511.
- `clk`  input  1  system clock, rising-edge active.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  1  serial line, idle high, asynchronous to `clk`.
- `data_rx`  output  8  last correctly received byte; holds its value until the next good frame.
- `valid`  output  1  one-cycle pulse: `data_rx` was just updated.
- `ferr`  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
- `busy`  output  1  high in every state except IDLE.
- `state`  output  2  debug: 0 IDLE, 1 START, 2 DATA, 3 STOP.
- `index`  output  3  debug: data-bit index being received.
- `counter`  output  9  debug: bit-time counter.

## Operation
- `din` passes through a 2-FF synchroniser; all logic below uses the synchronised value `s_din`.
- HALF = CLKS_PER_BIT/2, using integer floor.
- IDLE:
  - `counter` = 0 and `index` = 0.
  - The receiver is armed only after it has seen `s_din`=1 for at least one cycle since entering IDLE. This prevents a held-low line from retriggering.
  - Armed and `s_din`=0 → START.
- START:
  - `counter` increments each cycle.
  - At `counter`==HALF-1, sample `s_din`. If 0, go to DATA with `counter` set to 0. If 1, the start was a glitch: go to IDLE with no output pulse.
- DATA:
  - At `counter`==CLKS_PER_BIT-1, sample `s_din` into shift-register bit `index`, set `counter` to 0, and increment `index`.
  - After the sample at `index`==7, go to STOP with `index` set to 0.
- STOP:
  - At `counter`==CLKS_PER_BIT-1, sample `s_din`.
  - If 1: `data_rx` ← shift register, `valid` pulses, go to IDLE.
  - If 0: `ferr` pulses, `data_rx` is unchanged, go to IDLE unarmed.
- Every sample point lands at mid-bit, ±1 clock.
- Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught.
- `counter` width is 9 bits and never wraps, because `CLKS_PER_BIT` ≤ 511.
- `valid` and `ferr` are never high together.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - state IDLE, unarmed; synchroniser flops set to 1.
  - `counter`, `index`, shift register and `data_rx` all 0.
  - `valid`, `ferr` and `busy` all 0.
  - The partial frame is dropped.
- Input latency: 2 clocks from a `din` edge to a `s_din` edge.
- Start latency: `busy` rises 1 clock after `s_din` first reads 0 in armed IDLE.
- Output timing: `valid` or `ferr` is registered and high for exactly the one clock following the stop-sample edge. `data_rx` changes on that same edge.
- Frame-to-pulse: about 9.5 bit times after the start-bit falling edge, i.e. 2 + HALF + 9·CLKS_PER_BIT clocks (±1).
- `busy` falls together with the `valid`/`ferr` edge.

## Test plan
- **Reset, then byte 0xFF** (bit time 8687.5 ns at 31.25 ns clock):
  - `valid` pulses once, 1 clock wide; `data_rx`=0xFF; `ferr`=0.
- **Byte 0x55, then 0xA3 back-to-back** (second start bit immediately after the stop bit):
  - two `valid` pulses; `data_rx`=0x55, then 0xA3.
- **Glitch:** `din` low for 50 clocks (< HALF), then high.
  - `busy` high then low with no `valid` or `ferr`; state back to IDLE within HALF+3 clocks.
- **Framing error:** byte 0x3C with stop bit 0, line held low 3 bit times, then high, then a valid 0x81.
  - one `ferr` pulse; `data_rx` stays at the previous value; no retrigger while the line is low; then `valid` with 0x81.
- **Reset mid-frame:** `rst` pulsed during data bit 4 of 0x96.
  - all outputs 0 immediately; no pulse for the aborted frame; the next frame 0x42 is received correctly.
- **Baud tolerance:** `CLKS_PER_BIT`=16; frames sent at ±3% bit period with bytes 0x00 and 0xFF.
  - both bytes received correctly; `ferr`=0.
